// File: rtl/mpu_seq_pkg.sv
// Shared types and helpers for the MPU tile command sequencer:
// the FSM state encoding and the systolic flush length.
package mpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LD_C  = 3'd2,
        ST_OPACC = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } mpu_seq_state_e;

    // Cycles needed for partial sums to ripple through an ml x ml systolic array.
    function automatic int flush_len(input int ml);
        return 2 * ml - 1;
    endfunction

endpackage

// File: rtl/mpu_seq_perf.sv
// Saturating busy/stall cycle counters for the MPU command sequencer.
// Only instantiated when MPU_SEQ_PERF_EN is defined.
module mpu_seq_perf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        busy,
    input  logic        stall,
    output logic [31:0] perf_busy,
    output logic [31:0] perf_stall
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy && (perf_busy != '1)) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mpu_cmd_sequencer.sv
// Tile command sequencer for an ML x ML MPU: C load or clear, K outer-product
// steps, systolic flush and result drain. Optional perf counters: MPU_SEQ_PERF_EN.
module mpu_cmd_sequencer
    import mpu_seq_pkg::*;
#(
    parameter int ML = 4,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [KW-1:0] cmd_k,
    input  logic          cmd_load_c,
    input  logic          c_in_valid,
    output logic          c_in_ready,
    input  logic          ab_in_valid,
    output logic          ab_in_ready,
    output logic          c_valid,
    output logic          ab_valid,
    output logic          acc_clr,
    output logic          c_out_valid,
    input  logic          c_out_ready,
    output logic          done,
`ifdef MPU_SEQ_PERF_EN
    output logic [31:0]   perf_busy,
    output logic [31:0]   perf_stall,
`endif
    output logic [2:0]    state_dbg
);

    // Handshakes: a beat transfers in any cycle where valid and ready are both
    // high. Every ready is a pure decode of the registered state, so no ready
    // depends combinationally on a valid; valid may be held or dropped freely.

    localparam int RW = $clog2(ML + 1);
    localparam int FW = $clog2(flush_len(ML) + 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ML - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_len(ML) - 1);

    mpu_seq_state_e state_q, state_d;

    logic [KW-1:0] k_q;
    logic          load_c_q;
    logic [RW-1:0] row_cnt;
    logic [KW-1:0] k_cnt;
    logic [FW-1:0] flush_cnt;
    logic          row_beat;
    logic          k_beat;
    logic          state_entry;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        c_in_ready  = 1'b0;
        c_valid     = 1'b0;
        ab_in_ready = 1'b0;
        ab_valid    = 1'b0;
        acc_clr     = 1'b0;
        c_out_valid = 1'b0;
        done        = 1'b0;
        row_beat    = 1'b0;
        k_beat      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = cmd_load_c ? ST_LD_C : ST_CLR;
                end
            end
            ST_CLR: begin
                acc_clr = 1'b1;
                state_d = (k_q == '0) ? ST_FLUSH : ST_OPACC;
            end
            ST_LD_C: begin
                c_in_ready = 1'b1;
                c_valid    = c_in_valid;
                row_beat   = c_in_valid;
                if (c_in_valid && (row_cnt == ROW_LAST)) begin
                    state_d = (k_q == '0) ? ST_FLUSH : ST_OPACC;
                end
            end
            ST_OPACC: begin
                ab_in_ready = 1'b1;
                ab_valid    = ab_in_valid;
                k_beat      = ab_in_valid;
                if (ab_in_valid && (k_cnt == k_q - 1'b1)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                c_out_valid = 1'b1;
                row_beat    = c_out_ready;
                if (c_out_ready && (row_cnt == ROW_LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters restart on every state change, so the terminal beat of one
    // phase leaves them at zero for the next and they never wrap.
    assign state_entry = (state_d != state_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt   <= '0;
            k_cnt     <= '0;
            flush_cnt <= '0;
        end else if (state_entry) begin
            row_cnt   <= '0;
            k_cnt     <= '0;
            flush_cnt <= '0;
        end else begin
            if (row_beat) begin
                row_cnt <= row_cnt + 1'b1;
            end
            if (k_beat) begin
                k_cnt <= k_cnt + 1'b1;
            end
            if (state_q == ST_FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q      <= '0;
            load_c_q <= 1'b0;
        end else if (cmd_valid && (state_q == ST_IDLE)) begin
            k_q      <= cmd_k;
            load_c_q <= cmd_load_c;
        end
    end

    assign state_dbg = state_q;

`ifdef MPU_SEQ_PERF_EN
    logic perf_busy_ev;
    logic perf_stall_ev;

    assign perf_busy_ev  = (state_q != ST_IDLE);
    assign perf_stall_ev = ((state_q == ST_LD_C)  && !c_in_valid)  ||
                           ((state_q == ST_OPACC) && !ab_in_valid) ||
                           ((state_q == ST_DRAIN) && !c_out_ready);

    mpu_seq_perf u_perf (
        .clk        (clk),
        .reset_n    (reset_n),
        .busy       (perf_busy_ev),
        .stall      (perf_stall_ev),
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
    );
`else
    // The load-C flag is only observed through the state path in this build.
    logic unused_load_c;
    assign unused_load_c = load_c_q;
`endif

endmodule

// File: tb/tb_mpu_cmd_sequencer.sv
// Directed and randomized tile runs for mpu_cmd_sequencer (ML=4, KW=8),
// with per-tile expected beat counts and latency held in a queue.
module tb_mpu_cmd_sequencer;

    localparam int ML = 4;
    localparam int KW = 8;
    localparam int FL = 2 * ML - 1;
    localparam int W  = 40;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [KW-1:0] cmd_k;
    logic          cmd_load_c;
    logic          c_in_valid;
    logic          c_in_ready;
    logic          ab_in_valid;
    logic          ab_in_ready;
    logic          c_valid;
    logic          ab_valid;
    logic          acc_clr;
    logic          c_out_valid;
    logic          c_out_ready;
    logic          done;
    logic [2:0]    state_dbg;
`ifdef MPU_SEQ_PERF_EN
    logic [31:0]   perf_busy;
    logic [31:0]   perf_stall;
`endif

    logic [W-1:0] exp_q[$];
    int vec_cnt;
    int err_cnt;
    int cyc;

    mpu_cmd_sequencer #(.ML(ML), .KW(KW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_k       (cmd_k),
        .cmd_load_c  (cmd_load_c),
        .c_in_valid  (c_in_valid),
        .c_in_ready  (c_in_ready),
        .ab_in_valid (ab_in_valid),
        .ab_in_ready (ab_in_ready),
        .c_valid     (c_valid),
        .ab_valid    (ab_valid),
        .acc_clr     (acc_clr),
        .c_out_valid (c_out_valid),
        .c_out_ready (c_out_ready),
        .done        (done),
`ifdef MPU_SEQ_PERF_EN
        .perf_busy   (perf_busy),
        .perf_stall  (perf_stall),
`endif
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // zeros seen in pat before the need-th one; bits past 31 read as one
    function automatic int gaps(input logic [31:0] pat, input int need);
        int ones;
        int z;
        ones = 0;
        z = 0;
        for (int i = 0; i < 96 && ones < need; i++) begin
            if ((i < 32) ? pat[i] : 1'b1) ones++;
            else z++;
        end
        return z;
    endfunction

    // scoreboard push: {latency, c beats, ab beats, clr cycles, c_out_valid cycles}
    task automatic expect_tile(input int k, input int load, input int c_gaps,
                               input int ab_gaps, input int rdy_stalls);
        int lat;
        int n_c;
        int n_clr;
        lat   = (load != 0 ? ML + c_gaps : 1) + k + ab_gaps + FL + ML + rdy_stalls + 2;
        n_c   = (load != 0) ? ML : 0;
        n_clr = (load != 0) ? 0 : 1;
        exp_q.push_back({8'(lat), 8'(n_c), 8'(k), 8'(n_clr), 8'(ML + rdy_stalls)});
    endtask

    // driver + monitor: patterns advance one bit per cycle the matching ready is up
    task automatic run_tile(input int k, input int load, input logic [31:0] c_pat,
                            input logic [31:0] ab_pat, input logic [31:0] rdy_pat,
                            output int lat);
        int ci, ai, ri, t0, n_c, n_ab, n_clr, n_dr;
        bit got_done;
        logic [W-1:0] e;
        ci = 0; ai = 0; ri = 0; t0 = -1;
        n_c = 0; n_ab = 0; n_clr = 0; n_dr = 0;
        got_done = 1'b0;
        lat = 0;
        cmd_k      = KW'(k);
        cmd_load_c = (load != 0);
        cmd_valid  = 1'b1;
        for (int t = 0; t < 400 && !got_done; t++) begin
            c_in_valid  = (ci < 32) ? c_pat[ci]   : 1'b1;
            ab_in_valid = (ai < 32) ? ab_pat[ai]  : 1'b1;
            c_out_ready = (ri < 32) ? rdy_pat[ri] : 1'b1;
            @(negedge clk);
            if (cmd_valid && cmd_ready) t0 = cyc;
            check("c_ab_exclusive", {63'd0, c_valid & ab_valid}, 64'd0);
            n_c   += int'(c_valid);
            n_ab  += int'(ab_valid);
            n_clr += int'(acc_clr);
            n_dr  += int'(c_out_valid);
            if (c_in_ready)  ci++;
            if (ab_in_ready) ai++;
            if (c_out_valid) ri++;
            if (done) begin
                got_done = 1'b1;
                lat = cyc - t0 + 1;
                check("cmd_ready_in_done", {63'd0, cmd_ready}, 64'd0);
            end
            @(posedge clk);
            #1;
            if (t0 >= 0) cmd_valid = 1'b0;
        end
        cmd_valid   = 1'b0;
        c_in_valid  = 1'b0;
        ab_in_valid = 1'b0;
        c_out_ready = 1'b1;
        check("tile_done_seen", {63'd0, got_done}, 64'd1);
        e = exp_q.pop_front();
        check("latency",     64'(lat),   64'(e[39:32]));
        check("c_valid_cnt", 64'(n_c),   64'(e[31:24]));
        check("ab_valid_cnt",64'(n_ab),  64'(e[23:16]));
        check("acc_clr_cnt", 64'(n_clr), 64'(e[15:8]));
        check("c_out_cnt",   64'(n_dr),  64'(e[7:0]));
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"},   64'(state_dbg), 64'd0);
        check({tag, "_cmd_rdy"}, {63'd0, cmd_ready}, 64'd1);
        check({tag, "_strobes"},
              64'({c_in_ready, ab_in_ready, c_valid, ab_valid, acc_clr, c_out_valid, done}),
              64'd0);
    endtask

    initial begin
        int lat;
        int k, load, cg, ag, rg;
        bit seen;
        logic [31:0] cp, ap, rp;
`ifdef MPU_SEQ_PERF_EN
        logic [31:0] s0, b0;
`endif
        vec_cnt = 0;
        err_cnt = 0;
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_k       = '0;
        cmd_load_c  = 1'b0;
        c_in_valid  = 1'b0;
        ab_in_valid = 1'b0;
        c_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef MPU_SEQ_PERF_EN
        check("perf_busy_rst",  64'(perf_busy),  64'd0);
        check("perf_stall_rst", 64'(perf_stall), 64'd0);
`endif
        @(negedge clk);
        reset_n     = 1'b1;
        c_out_ready = 1'b1;
        @(posedge clk);
        #1;

        // baseline tile: 4 C beats, 3 ops, 7 flush, 4 drain, done -> 20 cycles
        expect_tile(3, 1, 0, 0, 0);
        run_tile(3, 1, '1, '1, '1, lat);
        check("baseline_lat_20", 64'(lat), 64'd20);

        // clear path
        expect_tile(2, 0, 0, 0, 0);
        run_tile(2, 0, '1, '1, '1, lat);

        // k=0 skips OPACC
        expect_tile(0, 1, 0, 0, 0);
        run_tile(0, 1, '1, '1, '1, lat);
        expect_tile(0, 0, 0, 0, 0);
        run_tile(0, 0, '1, '1, '1, lat);

        // ab_in_valid 1,0,0,1
`ifdef MPU_SEQ_PERF_EN
        s0 = perf_stall;
        b0 = perf_busy;
`endif
        expect_tile(2, 0, 0, 2, 0);
        run_tile(2, 0, '1, 32'hFFFF_FFF9, '1, lat);
`ifdef MPU_SEQ_PERF_EN
        check("perf_stall_delta", 64'(perf_stall - s0), 64'd2);
        check("perf_busy_delta",  64'(perf_busy - b0),  64'd17);
`endif

        // c_out_ready low for 5 drain cycles
        expect_tile(3, 1, 0, 0, 5);
        run_tile(3, 1, '1, '1, 32'hFFFF_FFE0, lat);
        check("drain_stall_lat", 64'(lat), 64'd25);

        // gaps in C source
        expect_tile(1, 1, 2, 0, 0);
        run_tile(1, 1, 32'hFFFF_FFF5, '1, '1, lat);

        // randomized tiles
        for (int n = 0; n < 6; n++) begin
            k    = $urandom_range(0, 6);
            load = $urandom_range(0, 1);
            cp   = $urandom();
            ap   = $urandom();
            rp   = $urandom();
            cg   = (load != 0) ? gaps(cp, ML) : 0;
            ag   = (k != 0) ? gaps(ap, k) : 0;
            rg   = gaps(rp, ML);
            expect_tile(k, load, cg, ag, rg);
            run_tile(k, load, cp, ap, rp, lat);
        end

        // reset during first OPACC beat, then a fresh tile
        cmd_k       = KW'(3);
        cmd_load_c  = 1'b0;
        cmd_valid   = 1'b1;
        ab_in_valid = 1'b1;
        @(negedge clk);
        check("mid_cmd_accept", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (ab_in_ready) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("mid_opacc_reached", {63'd0, seen}, 64'd1);
        check("mid_step1_beat", {63'd0, ab_valid}, 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        reset_n     = 1'b1;
        ab_in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("no_resume");
        @(posedge clk);
        #1;
        expect_tile(1, 1, 0, 0, 0);
        run_tile(1, 1, '1, '1, '1, lat);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mpu_cmd_sequencer.md
MPU_CMD_SEQUENCER -- requirements
Module: mpu_cmd_sequencer

Interface
REQ-001 Param ML, default 4, MPU array dimension: rows shifted per C load or drain; ML >= 2.
REQ-002 Param KW, default 8, width of the K-step count.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  tile command handshake; a command is accepted when both are high.
REQ-006 cmd_k  in  KW  number of outer-product steps for the tile.
REQ-007 cmd_load_c  in  1  1 = shift C in from the C source; 0 = clear the accumulators instead.
REQ-008 c_in_valid / c_in_ready  in / out  1 / 1  C-source row handshake.
REQ-009 ab_in_valid / ab_in_ready  in / out  1 / 1  A/B operand handshake.
REQ-010 c_valid, ab_valid, acc_clr  out  1 each  array strobes: C shift-in, operand accumulate, accumulator clear.
REQ-011 c_out_valid / c_out_ready  out / in  1 / 1  result-row drain handshake.
REQ-012 done  out  1  one-cycle pulse when a tile completes.

Function
REQ-013 The FSM SHALL have these states: IDLE, CLR, LD_C, OPACC, FLUSH, DRAIN, DONE.
REQ-014 cmd_ready SHALL equal (state==IDLE); in IDLE, an accepted command SHALL latch cmd_k and cmd_load_c and go to LD_C if cmd_load_c=1, otherwise to CLR.
REQ-015 CLR SHALL last exactly 1 cycle with acc_clr=1, then go to OPACC.
REQ-016 In LD_C: c_in_ready=1 and c_valid=c_in_valid; each handshake increments a row counter; after the ML-th beat, go to OPACC; no beat means no count.
REQ-017 In OPACC: ab_in_ready=1 and ab_valid=ab_in_valid; each handshake increments a K counter; after the cmd_k-th beat, go to FLUSH.
REQ-018 If latched cmd_k=0, the FSM SHALL bypass OPACC and go directly from LD_C or CLR to FLUSH, with no ab_valid asserted.
REQ-019 FLUSH SHALL last exactly 2*ML-1 cycles so that systolic partial sums settle, then go to DRAIN.
REQ-020 In DRAIN: c_out_valid=1; each cycle with c_out_ready=1 counts a row; after ML rows, go to DONE; c_out_ready=0 stalls the FSM indefinitely.
REQ-021 DONE SHALL assert done for 1 cycle, then go to IDLE; a new command is accepted no earlier than the cycle after DONE.
REQ-022 All handshake-ready outputs SHALL be registered-state decodes with no combinational path from any valid input.
REQ-023 Counters SHALL be sized $clog2(ML+1) and KW; they SHALL reset to 0 on each state entry and never wrap.
REQ-024 All strobes SHALL be 0 outside their owning state; c_valid and ab_valid SHALL never be high in the same cycle.

Reset
REQ-025 Asserting reset_n low at any time, including mid-tile, SHALL force state IDLE, clear all counters and latched fields, and drive every output to 0 except cmd_ready, which is 1 after reset.
REQ-026 No partial tile SHALL resume after reset release.

Configuration
REQ-027 With MPU_SEQ_PERF_EN defined, the block SHALL add outputs perf_busy[31:0] (cycles with state!=IDLE) and perf_stall[31:0] (LD_C/OPACC cycles with no input beat, plus DRAIN cycles with c_out_ready=0); both saturate at all-ones and clear on reset.
REQ-028 Without MPU_SEQ_PERF_EN, those ports and counters SHALL be absent.

Structure
REQ-029 Package mpu_seq_pkg SHALL hold the state enum typedef and the FLUSH-length function (2*ML-1).
REQ-030 The performance counters SHALL live in sub-module mpu_seq_perf, instantiated only under MPU_SEQ_PERF_EN.

Verification (ML=4)
REQ-031 cmd_k=3, load_c=1, all sources always valid, c_out_ready=1: 4 c_valid, then 3 ab_valid, then 7 FLUSH cycles, 4 c_out_valid, then done; the command-to-done interval is 20 cycles.
REQ-032 cmd_k=2, load_c=0: exactly 1 acc_clr cycle, no c_valid, 2 ab_valid, done.
REQ-033 cmd_k=0, load_c=1: no ab_valid; FLUSH entered directly after the 4th C beat.
REQ-034 ab_in_valid toggling 1,0,0,1 with cmd_k=2: exactly 2 ab_valid, and perf_stall increments by 2 (PERF_EN build).
REQ-035 c_out_ready held 0 for 5 cycles in DRAIN: c_out_valid holds and done is delayed 5 cycles.
REQ-036 reset_n pulsed low during OPACC step 1: next cycle IDLE, outputs 0, cmd_ready=1; a fresh command runs to completion.
